apb_uart_master: RTL and testbench

- Bus initiator that drives the UART peripheral's register interface (paddr, read/write strobes, data) using APB3-style SETUP/ACCESS transfers.
- Accepts one command at a time from a local requester over a valid/ready handshake.
- Returns read data and an error flag over a response handshake.
- Sits between a host sequencer (boot loader, test controller) and the uart block's bus side.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/apb_timeout_cnt.sv | 30 +++
 rtl/apb_uart_master.sv | 126 ++++++++++++
 tb/tb_apb_uart_master.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus side: widths, APB master state encoding and register map.
// No logic; imported by the APB master and its helpers.
package uart_pkg;

  localparam int BITWIDTH   = 8;
  localparam int APB_ADDR_W = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } apb_state_t;

  localparam logic [APB_ADDR_W-1:0] RX_DATA = 2'b00;
  localparam logic [APB_ADDR_W-1:0] TX_DATA = 2'b01;
  localparam logic [APB_ADDR_W-1:0] STATUS  = 2'b10;

  // psel is high for the whole SETUP/ACCESS window of a transfer.
  function automatic logic in_transfer(input apb_state_t s);
    return (s == SETUP) || (s == ACCESS);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter: counts enabled cycles, saturates at TIMEOUT, clear has priority.
// expired flags the enabled cycle whose tick reaches TIMEOUT (or any tick once saturated).
module apb_timeout_cnt #(
  parameter int TIMEOUT = 255,
  localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Combinational so the master can abort in the same cycle the limit is hit.
  assign expired = enable && (count >= LIMIT - CNT_W'(1));

endmodule

// File: rtl/apb_uart_master.sv
// APB3 initiator for the UART register block: one command in flight, SETUP/ACCESS, response held until consumed.
// Zero-wait latency: accept c0, SETUP c1, ACCESS c2, rsp_valid c3, cmd_ready again c4; no new command while a response is pending.
module apb_uart_master
  import uart_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = BITWIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_t       state;
  apb_state_t       state_nxt;
  logic             wait_tick;
  logic             cnt_clear;
  logic             timed_out;
  logic [CNT_W-1:0] wait_cnt;

  // reset_n is active-high despite its name.
  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (reset_n),
    .enable  (wait_tick),
    .clear   (cnt_clear),
    .count   (wait_cnt),
    .expired (timed_out)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake and bus strobes decode straight from the state register, so an
  // asynchronous reset drops psel/penable/rsp_valid without a clock edge.
  always_comb begin
    state_nxt = state;
    wait_tick = 1'b0;
    cnt_clear = 1'b0;
    cmd_ready = (state == IDLE);
    psel      = in_transfer(state);
    penable   = (state == ACCESS);
    rsp_valid = (state == RESP);
    case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        wait_tick = !pready;
        if (pready || timed_out) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
          cnt_clear = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      // pready in the timeout cycle itself completes the transfer normally.
      if (state == ACCESS) begin
        if (pready) begin
          rsp_rdata <= pwrite ? '0 : prdata;
          rsp_err   <= pslverr;
        end else if (timed_out) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

  a_bus_stable: assert property (@(posedge clk) disable iff (reset_n)
    (state == ACCESS) |-> ($stable(paddr) && $stable(pwrite) && $stable(pwdata)));

  a_rsp_hold: assert property (@(posedge clk) disable iff (reset_n)
    ((state == RESP) && !rsp_ready) |=> ((state == RESP) && $stable(rsp_rdata) && $stable(rsp_err)));

  a_cnt_sat: assert property (@(posedge clk) disable iff (reset_n)
    wait_cnt <= CNT_W'(TIMEOUT));

endmodule

// File: tb/tb_apb_uart_master.sv
// Randomized self-checking bench for apb_uart_master with a transaction-level reference model.
module tb_apb_uart_master;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       psel, penable, pwrite;
  logic [1:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         access_cycles;
    bit         ready_at_start;
    bit         setup_ok;
    bit         bus_stable;
    bit         rsp_vld;
    logic [7:0] rdata;
    logic       err;
    bit         resp_stable;
    bit         idle_after;
  } obs_t;

  apb_uart_master #(.ADDR_W(2), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Transaction-level expectation: responder withholds pready for `waits` ACCESS
  // cycles; the master gives up after TIMEOUT ACCESS cycles.
  function automatic void model(input logic wr, input logic [7:0] rd, input int waits,
                                input logic serr, output int acc, output logic [7:0] erd,
                                output logic eerr);
    if (waits >= TIMEOUT) begin
      acc = TIMEOUT; erd = 8'h00; eerr = 1'b1;
    end else begin
      acc = waits + 1; erd = wr ? 8'h00 : rd; eerr = serr;
    end
  endfunction

  // Drives one command and acts as responder; records observations only.
  // Entered and left at a falling edge. cmd_valid is kept high with junk after acceptance.
  task automatic xfer(input logic wr, input logic [1:0] addr, input logic [7:0] wd,
                      input int waits, input logic serr, input logic [7:0] rd,
                      input int hold, input logic late, output obs_t o);
    int k;
    o.access_cycles = 0; o.setup_ok = 0; o.bus_stable = 1; o.rsp_vld = 0;
    o.rdata = '0; o.err = 0; o.resp_stable = 1; o.idle_after = 0;
    o.ready_at_start = cmd_ready;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(negedge clk);
    o.setup_ok = psel && !penable && !cmd_ready && !rsp_valid;
    if (paddr !== addr || pwrite !== wr || pwdata !== wd) o.bus_stable = 0;
    cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wd;
    k = 0;
    @(negedge clk);
    while (psel && penable && k <= TIMEOUT + 8) begin
      if (paddr !== addr || pwrite !== wr || pwdata !== wd || rsp_valid || cmd_ready) o.bus_stable = 0;
      pready  = (k >= waits);
      pslverr = (k >= waits) ? serr : 1'($urandom);
      prdata  = (k >= waits) ? rd : 8'($urandom);
      k++;
      @(negedge clk);
    end
    o.access_cycles = k;
    pready = late; pslverr = 1'b1; prdata = 8'($urandom);
    o.rsp_vld = rsp_valid && !psel && !penable && !cmd_ready;
    o.rdata = rsp_rdata; o.err = rsp_err;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== o.rdata || rsp_err !== o.err || cmd_ready || psel) o.resp_stable = 0;
    end
    pready = 1'b0; pslverr = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    o.idle_after = cmd_ready && !rsp_valid && !psel && !penable;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if ({rsp_rdata, rsp_err} !== 9'h0) begin n_fail++; $display("FAIL reset_rsp got=%h/%b exp=00/0", rsp_rdata, rsp_err); end
    n_checks++; if ({psel, penable, pwrite} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got=%b exp=000", {psel, penable, pwrite}); end
    n_checks++; if ({paddr, pwdata} !== 10'h0) begin n_fail++; $display("FAIL reset_bus got=%h/%h exp=0/00", paddr, pwdata); end
  endtask

  task automatic test_write_zero_wait();
    obs_t o;
    xfer(1'b1, 2'b01, 8'hA5, 0, 1'b0, 8'h77, 0, 1'b0, o);
    n_checks++; if (!(o.ready_at_start && o.setup_ok)) begin n_fail++; $display("FAIL wr0_setup got=%b%b exp=11", o.ready_at_start, o.setup_ok); end
    n_checks++; if (!o.bus_stable) begin n_fail++; $display("FAIL wr0_bus paddr/pwdata not held at 1/A5"); end
    n_checks++; if (o.access_cycles !== 1) begin n_fail++; $display("FAIL wr0_access got=%0d exp=1", o.access_cycles); end
    n_checks++; if (!o.rsp_vld || o.rdata !== 8'h00 || o.err !== 1'b0) begin n_fail++; $display("FAIL wr0_rsp got=%b/%h/%b exp=1/00/0", o.rsp_vld, o.rdata, o.err); end
    n_checks++; if (!o.idle_after) begin n_fail++; $display("FAIL wr0_idle got=0 exp=1"); end
  endtask

  task automatic test_read_wait();
    obs_t o;
    xfer(1'b0, 2'b00, 8'h5A, 3, 1'b0, 8'h3C, 0, 1'b0, o);
    n_checks++; if (o.access_cycles !== 4) begin n_fail++; $display("FAIL rdw_access got=%0d exp=4", o.access_cycles); end
    n_checks++; if (!o.bus_stable) begin n_fail++; $display("FAIL rdw_bus not held"); end
    n_checks++; if (!o.rsp_vld || o.rdata !== 8'h3C || o.err !== 1'b0) begin n_fail++; $display("FAIL rdw_rsp got=%b/%h/%b exp=1/3c/0", o.rsp_vld, o.rdata, o.err); end
  endtask

  task automatic test_slave_err();
    obs_t o;
    xfer(1'b1, 2'b10, 8'h11, 1, 1'b1, 8'h00, 1, 1'b0, o);
    n_checks++; if (o.err !== 1'b1 || o.rdata !== 8'h00) begin n_fail++; $display("FAIL slverr_rsp got=%h/%b exp=00/1", o.rdata, o.err); end
    n_checks++; if (!o.idle_after) begin n_fail++; $display("FAIL slverr_idle got=0 exp=1"); end
  endtask

  task automatic test_timeout();
    obs_t o;
    xfer(1'b0, 2'b00, 8'h42, 100, 1'b0, 8'hEE, 2, 1'b1, o);
    n_checks++; if (o.access_cycles !== TIMEOUT) begin n_fail++; $display("FAIL tmo_access got=%0d exp=%0d", o.access_cycles, TIMEOUT); end
    n_checks++; if (!o.rsp_vld || o.rdata !== 8'h00 || o.err !== 1'b1) begin n_fail++; $display("FAIL tmo_rsp got=%b/%h/%b exp=1/00/1", o.rsp_vld, o.rdata, o.err); end
    n_checks++; if (!o.resp_stable) begin n_fail++; $display("FAIL tmo_late_pready response changed"); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    xfer(1'b1, 2'b01, 8'hC3, 0, 1'b0, 8'h00, 5, 1'b0, o1);
    n_checks++; if (!o1.resp_stable) begin n_fail++; $display("FAIL b2b_hold rsp or cmd_ready moved during back-pressure"); end
    xfer(1'b0, 2'b10, 8'h00, 0, 1'b0, 8'h96, 0, 1'b0, o2);
    n_checks++; if (!(o2.ready_at_start && o2.setup_ok)) begin n_fail++; $display("FAIL b2b_next got=%b%b exp=11", o2.ready_at_start, o2.setup_ok); end
    n_checks++; if (o2.rdata !== 8'h96 || o2.err !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp got=%h/%b exp=96/0", o2.rdata, o2.err); end
  endtask

  task automatic test_random();
    obs_t o;
    logic wr, serr, eerr;
    logic [1:0] addr;
    logic [7:0] wd, rd, erd;
    int waits, hold, eacc;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom); serr = 1'($urandom); addr = 2'($urandom);
      wd = 8'($urandom); rd = 8'($urandom);
      waits = $urandom_range(0, 5); hold = $urandom_range(0, 2);
      model(wr, rd, waits, serr, eacc, erd, eerr);
      xfer(wr, addr, wd, waits, serr, rd, hold, 1'b0, o);
      n_checks++;
      if (o.access_cycles !== eacc || o.rdata !== erd || o.err !== eerr || !o.rsp_vld)
        begin n_fail++; $display("FAIL rnd%0d got acc=%0d rd=%h err=%b vld=%b exp acc=%0d rd=%h err=%b vld=1", n, o.access_cycles, o.rdata, o.err, o.rsp_vld, eacc, erd, eerr); end
      n_checks++;
      if (!(o.setup_ok && o.bus_stable && o.resp_stable && o.idle_after))
        begin n_fail++; $display("FAIL rnd%0d_proto got setup=%b bus=%b hold=%b idle=%b exp 1111", n, o.setup_ok, o.bus_stable, o.resp_stable, o.idle_after); end
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'b01; cmd_wdata = 8'h5F;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (!(psel && penable)) begin n_fail++; $display("FAIL rstmid_access got=%b%b exp=11", psel, penable); end
    #2 reset_n = 1'b1;
    #1;
    n_checks++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin n_fail++; $display("FAIL rstmid_async got=%b exp=0001", {psel, penable, rsp_valid, cmd_ready}); end
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL rstmid_release got=%b exp=100", {cmd_ready, psel, rsp_valid}); end
    // Pending response discarded by reset.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'b10;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); pready = 1'b1; prdata = 8'hD7;
    @(negedge clk); pready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hD7) begin n_fail++; $display("FAIL rstresp_pre got=%b/%h exp=1/d7", rsp_valid, rsp_rdata); end
    #2 reset_n = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rstresp_async got=%b/%h exp=0/00", rsp_valid, rsp_rdata); end
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL rstresp_after got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask

  initial begin
    reset_n = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    test_write_zero_wait();
    test_read_wait();
    test_slave_err();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
